// File: rtl/mat_result_display_seq_pkg.sv
// Shared types and constants for the matrix-result seven-segment sweep.
package mat_disp_pkg;

  localparam int ELEM_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_DASH  = 8'h40;
  localparam logic [7:0] SEG_E     = 8'h79;
  localparam logic [7:0] SEG_DP    = 8'h80;

endpackage

// File: rtl/mat_result_display_seq_if.sv
// Result handoff from the 2x2 multiplier into the display sequencer.
interface mat_result_display_seq_if;
  import mat_disp_pkg::*;

  logic                  res_valid;
  logic [4*ELEM_W-1:0]   res_data;
  logic                  res_err;
  logic                  res_ready;

  modport master (output res_valid, output res_data, output res_err, input  res_ready);
  modport slave  (input  res_valid, input  res_data, input  res_err, output res_ready);
endinterface

// File: rtl/mat_result_display_seq_seg7.sv
// Digit-to-segment decoder {g,f,e,d,c,b,a}; anything above 8 renders a dash.
module seg7_encode
  import mat_disp_pkg::*;
(
  input  logic [ELEM_W-1:0] val_i,
  output logic [6:0]        seg_o
);

  always_comb begin
    seg_o = SEG_DASH[6:0];
    case (val_i)
      4'd0: seg_o = 7'h3F;
      4'd1: seg_o = 7'h06;
      4'd2: seg_o = 7'h5B;
      4'd3: seg_o = 7'h4F;
      4'd4: seg_o = 7'h66;
      4'd5: seg_o = 7'h6D;
      4'd6: seg_o = 7'h7D;
      4'd7: seg_o = 7'h07;
      4'd8: seg_o = 7'h7F;
      default: seg_o = SEG_DASH[6:0];
    endcase
  end

endmodule

// File: rtl/mat_result_display_seq.sv
// Latches one multiplier result and sweeps c11..c22 across one seven-segment digit.
// Define GAP_BLANK_EN to insert a blank interval between consecutive elements.
module mat_result_display_seq
  import mat_disp_pkg::*;
#(
  parameter int DWELL_CYCLES = 10000000,
  parameter int CNT_W        = $clog2(DWELL_CYCLES),
  parameter int GAP_CYCLES   = 1000000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  mat_result_display_seq_if.slave   res,
  output logic [7:0]                seg_out,
  output logic [1:0]                elem_idx,
  output logic                      busy
);

  // One counter serves both dwell and gap phases, so size it for the longer.
  localparam int GAP_W = $clog2(GAP_CYCLES);
  localparam int CW    = (CNT_W > GAP_W) ? CNT_W : GAP_W;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [1:0]          idx_q, idx_d;
  logic [4*ELEM_W-1:0] data_q, data_d;
  logic                err_q, err_d;
  logic [7:0]          seg_q, seg_d;
  logic                busy_q, busy_d;
  logic                load, blank;
  logic [ELEM_W-1:0]   enc_in;
  logic [6:0]          enc_seg;

  assign res.res_ready = (state_q == IDLE) && ena;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    err_d   = err_q;
    busy_d  = busy_q;
    load    = 1'b0;
    blank   = 1'b0;
    if (ena) begin
      case (state_q)
        IDLE: if (res.res_valid) begin
          data_d  = res.res_data;
          err_d   = res.res_err;
          state_d = SHOW;
          idx_d   = 2'd0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          load    = 1'b1;
        end
        SHOW: if (cnt_q == CW'(DWELL_CYCLES - 1)) begin
          cnt_d = '0;
          if (idx_q == 2'd3) begin
            state_d = IDLE;
            idx_d   = 2'd0;
            busy_d  = 1'b0;
            blank   = 1'b1;
          end else begin
`ifdef GAP_BLANK_EN
            state_d = GAP;
            blank   = 1'b1;
`else
            idx_d   = idx_q + 2'd1;
            load    = 1'b1;
`endif
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        GAP: if (cnt_q == CW'(GAP_CYCLES - 1)) begin
          cnt_d   = '0;
          idx_d   = idx_q + 2'd1;
          state_d = SHOW;
          load    = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Decode from next-state data so the first element shows the cycle after accept.
  assign enc_in = data_d[idx_d*ELEM_W +: ELEM_W];

  seg7_encode u_enc (
    .val_i (enc_in),
    .seg_o (enc_seg)
  );

  always_comb begin
    seg_d = seg_q;
    if (blank) begin
      seg_d = SEG_BLANK;
    end else if (load) begin
      seg_d[6:0] = err_d ? SEG_E[6:0] : enc_seg;
      seg_d[7]   = (idx_d == 2'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      data_q  <= '0;
      err_q   <= 1'b0;
      seg_q   <= SEG_BLANK;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      err_q   <= err_d;
      seg_q   <= seg_d;
      busy_q  <= busy_d;
    end
  end

  assign seg_out  = seg_q;
  assign elem_idx = idx_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_mat_result_display_seq.sv
// Scoreboard bench: stimulus pushes per-cycle expected display frames, a monitor pops them.
module tb_mat_result_display_seq;

  localparam int DWELL = 4;
  localparam int GAPC  = 2;
  localparam logic [7:0] SEGTAB [0:8] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                          8'h6D, 8'h7D, 8'h07, 8'h7F};

  typedef struct packed {
    logic       rdy;
    logic       bsy;
    logic [1:0] idx;
    logic [7:0] seg;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] seg_out;
  logic [1:0] elem_idx;
  logic       busy;

  int tests = 0;
  int fails = 0;
  frame_t q[$];
  frame_t prev, act, expv;
  string  nm;

  mat_result_display_seq_if bus ();

  mat_result_display_seq #(.DWELL_CYCLES(DWELL), .GAP_CYCLES(GAPC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .res      (bus.slave),
    .seg_out  (seg_out),
    .elem_idx (elem_idx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] seg_of(input logic [15:0] d, input logic e, input int k);
    int v;
    logic [7:0] s;
    v = int'((d >> (4 * k)) & 16'hF);
    if (e)           s = 8'h79;
    else if (v <= 8) s = SEGTAB[v];
    else             s = 8'h40;
    if (k == 0) s = s | 8'h80;
    return s;
  endfunction

  // Reference: a whole sweep expressed as the list of frames seen after each edge.
  task automatic push_sweep(input logic [15:0] d, input logic e);
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < DWELL; c++) q.push_back('{1'b0, 1'b1, 2'(k), seg_of(d, e, k)});
`ifdef GAP_BLANK_EN
      if (k < 3)
        for (int c = 0; c < GAPC; c++) q.push_back('{1'b0, 1'b1, 2'(k), 8'h00});
`endif
    end
    q.push_back('{1'b1, 1'b0, 2'd0, 8'h00});
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic e,
                       input logic en, input logic rs);
    @(negedge clk);
    bus.res_valid = v;
    bus.res_data  = d;
    bus.res_err   = e;
    ena           = en;
    rst_n         = rs;
    if (v && en && rs && q.size() == 0) push_sweep(d, e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic check(input string name, input frame_t a, input frame_t x);
    tests++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s @%0t: got seg=%h idx=%0d busy=%b ready=%b, want seg=%h idx=%0d busy=%b ready=%b",
               name, $time, a.seg, a.idx, a.bsy, a.rdy, x.seg, x.idx, x.bsy, x.rdy);
    end
  endtask

  always @(posedge clk) begin
    #1;
    act = '{bus.res_ready, busy, elem_idx, seg_out};
    if (!rst_n) begin
      q.delete();
      expv = '{ena, 1'b0, 2'd0, 8'h00};
      nm = "reset";
    end else if (!ena) begin
      expv = prev;
      expv.rdy = 1'b0;
      nm = "freeze";
    end else if (q.size() > 0) begin
      expv = q.pop_front();
      nm = "sweep";
    end else begin
      expv = '{1'b1, 1'b0, 2'd0, 8'h00};
      nm = "idle";
    end
    check(nm, act, expv);
    prev = act;
  end

  initial begin
    int guard;
    bus.res_valid = 1'b0;
    bus.res_data  = 16'h0;
    bus.res_err   = 1'b0;
    repeat (3) drive(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    idle(2);
    // Directed patterns: normal, maximum, out-of-range, error.
    drive(1'b1, 16'h0214, 1'b0, 1'b1, 1'b1); idle(30);
    drive(1'b1, 16'h8888, 1'b0, 1'b1, 1'b1); idle(30);
    drive(1'b1, 16'h000F, 1'b0, 1'b1, 1'b1); idle(30);
    drive(1'b1, 16'h1234, 1'b1, 1'b1, 1'b1); idle(30);
    // Back-pressure mid-sweep and on the end-of-sweep edge.
    drive(1'b1, 16'h0214, 1'b0, 1'b1, 1'b1); idle(1);
    drive(1'b1, 16'h0001, 1'b0, 1'b1, 1'b1);
    guard = 0;
    while (q.size() > 1 && guard < 100) begin idle(1); guard++; end
    drive(1'b1, 16'h0001, 1'b0, 1'b1, 1'b1);
    idle(5);
    // Freeze in element 1, then abort in element 2.
    drive(1'b1, 16'h0214, 1'b0, 1'b1, 1'b1); idle(5);
    repeat (10) drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    idle(30);
    drive(1'b1, 16'h0214, 1'b0, 1'b1, 1'b1); idle(9);
    drive(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    idle(5);
    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 3) == 0, 16'($urandom()), $urandom_range(0, 7) == 0,
            $urandom_range(0, 15) != 0, $urandom_range(0, 199) != 0);
    end
    idle(40);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mat_result_display_seq.md
Name: mat_result_display_seq

Overview:
- Downstream stage of the 2x2 matrix multiplier.
- Latches one packed result: four 4-bit elements c11, c12, c21, c22, plus the error flag.
- Shows the elements one at a time on a single seven-segment digit, each for a programmable dwell time, then returns to idle.
- Gives the demo a human-readable output from the same 8-bit output bus.

Parameters:
- DWELL_CYCLES, 10000000, clk cycles each element is displayed (>=2).
- CNT_W, $clog2(DWELL_CYCLES), width of the dwell counter.
- GAP_CYCLES, 1000000, blank cycles between elements (used only with GAP_BLANK_EN).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- ena  in  1  global enable; low freezes all state.
- res_valid  in  1  one-cycle strobe: new result on res_data/res_err.
- res_data  in  16  {c22[15:12], c21[11:8], c12[7:4], c11[3:0]}, unsigned.
- res_err  in  1  operand-range error from the multiplier.
- res_ready  out  1  block can accept a result.
- seg_out  out  8  {dp,g,f,e,d,c,b,a}, active-high, registered.
- elem_idx  out  2  index of element currently shown (0=c11 .. 3=c22), registered.
- busy  out  1  sweep in progress, registered.

Behaviour:
- Reset (rst_n low at clk edge):
  - state=IDLE, seg_out=0x00, elem_idx=0, busy=0, dwell counter=0, latched data/err cleared.
  - Reset mid-sweep aborts immediately.
- States: IDLE, SHOW (plus GAP when the optional feature is enabled).
- res_ready = (state==IDLE) && ena, combinational from the state register.
- Accept condition: res_valid && res_ready at a clk edge. On that edge:
  - latch res_data and res_err;
  - state->SHOW, elem_idx=0, busy=1, counter=0;
  - seg_out = code(c11) | dp.
- Latency: first element is visible on the cycle after the accept.
- SHOW dwell:
  - counter increments each enabled cycle.
  - At counter==DWELL_CYCLES-1: counter->0 and elem_idx advances; seg_out is loaded with the next element's code on the same edge.
  - Each element is therefore visible for exactly DWELL_CYCLES cycles.
- End of sweep: after element 3's final cycle, state->IDLE, seg_out=0x00, busy=0, elem_idx=0.
- Segment encoding:
  - 0..8: 0x3F, 0x06, 0x5B, 0x4F, 0x66, 0x6D, 0x7D, 0x07, 0x7F.
  - Values 9..15 are not producible by the multiplier; they display dash 0x40.
- dp (bit 7) is lit only while elem_idx==0, marking the start of the sweep.
- If the latched err=1, all four slots display 'E' (0x79); slot 0 still has dp lit (0xF9).
- res_valid while not in IDLE: ignored, not queued, latched data unchanged.
- ena low: state, counter, idx and outputs hold; res_ready=0. Resumes where it stopped.
- Valid and end-of-sweep on the same edge: the result is not accepted, because ready is derived from the current state (SHOW).

Optional Feature:
- Macro: GAP_BLANK_EN.
- Defined:
  - After each element's dwell, except element 3, enter GAP for GAP_CYCLES cycles with seg_out=0x00, elem_idx unchanged, busy=1.
  - Then load the next element and return to SHOW.
  - The counter is shared, compared against GAP_CYCLES-1.
- Undefined: no GAP state; elements follow back-to-back as described above.

Decomposition:
- Package mat_disp_pkg:
  - state enum (IDLE, SHOW, GAP);
  - segment constants SEG_BLANK, SEG_DASH, SEG_E, SEG_DP;
  - element width ELEM_W=4.
- Sub-module seg7_encode: combinational 4-bit value -> 7-bit segment pattern (0..8, else dash).
- The top level holds the FSM, counter, latches, dp/err overlay and output registers.

Test Plan (DWELL_CYCLES=4, GAP_CYCLES=2):
- Normal sweep: res_data=0x0214, err=0, valid 1 cycle -> seg_out 0xE6, 0x06, 0x5B, 0x3F for 4 cycles each, elem_idx 0..3, then 0x00 with busy=0 and ready=1.
- Maximum values: res_data=0x8888 -> 0xFF, 0x7F, 0x7F, 0x7F. Out-of-range: res_data=0x000F -> first slot 0xC0.
- Error: res_err=1, res_data=0x1234 -> 0xF9, 0x79, 0x79, 0x79, then idle.
- Back-pressure: second valid (0x0001) 2 cycles after the first accept -> ignored, ready=0, original sweep continues unchanged. Valid on the end-of-sweep edge is also ignored.
- Freeze and abort:
  - ena low for 10 cycles mid element 1 -> outputs frozen, element 1 then shows for its remaining cycles (4 total).
  - rst_n low mid element 2 -> next edge seg_out=0x00, idx=0, busy=0.
- GAP_BLANK_EN defined, res_data=0x0214 -> 0xE6x4, 0x00x2, 0x06x4, 0x00x2, 0x5Bx4, 0x00x2, 0x3Fx4, then idle (no trailing gap).
